// File: rtl/param_acc_cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcodes, FSM states and
// the reserved-opcode predicate.
package param_acc_cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_LDI, OP_AND, OP_OR,
      OP_XOR, OP_JMP, OP_JZ, OP_JC, OP_RSVC, OP_RSVD, OP_RSVE, OP_HLT
   } opcode_e;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_e;

   function automatic logic is_reserved(opcode_e op);
      return op inside {OP_RSVC, OP_RSVD, OP_RSVE};
   endfunction

endpackage

// File: rtl/param_acc_cpu_alu.sv
// Combinational datapath: produces the new accumulator value, carry/borrow and
// the zero indication for the instruction in EXEC.
module param_acc_cpu_alu
   import param_acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  opcode_e             opcode_i,
   input  logic [DATA_W-1:0]   acc_i,
   input  logic [DATA_W-1:0]   operand_i,
   output logic [DATA_W-1:0]   result_o,
   output logic                carry_o,
   output logic                z_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
   // The extra MSB of the difference is the borrow (acc < operand).
   assign diff = {1'b0, acc_i} - {1'b0, operand_i};

   always_comb begin
      result_o = acc_i;
      carry_o  = 1'b0;
      case (opcode_i)
         OP_LDA, OP_LDI: result_o = operand_i;
         OP_ADD:         {carry_o, result_o} = sum;
         OP_SUB:         {carry_o, result_o} = diff;
         OP_AND:         result_o = acc_i & operand_i;
         OP_OR:          result_o = acc_i | operand_i;
         OP_XOR:         result_o = acc_i ^ operand_i;
         default:        ;
      endcase
   end

   assign z_o = (result_o == '0);

endmodule

// File: rtl/param_acc_cpu.sv
// Stand-alone accumulator CPU with internal imem/dmem, a load port usable while
// idle or halted, Z/C flags, conditional jumps and a retired-instruction counter.
module param_acc_cpu
   import param_acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OPND_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              prog_we,
   input  logic              prog_dmem,
   input  logic [OPND_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic [OPND_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              zero,
   output logic              carry,
   output logic              halt,
   output logic              illegal,
   output logic              busy,
   output logic [CNT_W-1:0]  retired
);

   localparam int IW    = 4 + OPND_W;
   localparam int DEPTH = 2 ** OPND_W;

   logic [IW-1:0]     imem [DEPTH];
   logic [DATA_W-1:0] dmem [DEPTH];

   state_e            state_q;
   logic [IW-1:0]     ir_q;
   logic [OPND_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] acc_q;
   logic              z_q, c_q, halt_q, ill_q;
   logic [CNT_W-1:0]  ret_q;

   opcode_e           op;
   logic [OPND_W-1:0] arg;
   logic [DATA_W-1:0] alu_b, alu_res;
   logic              alu_c, alu_z;

   assign op    = opcode_e'(ir_q[IW-1:OPND_W]);
   assign arg   = ir_q[OPND_W-1:0];
   assign alu_b = (op == OP_LDI) ? DATA_W'(arg) : dmem[arg];
   assign busy  = (state_q == ST_FETCH) || (state_q == ST_EXEC);

   param_acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode_i  (op),
      .acc_i     (acc_q),
      .operand_i (alu_b),
      .result_o  (alu_res),
      .carry_o   (alu_c),
      .z_o       (alu_z)
   );

   always_comb begin
      pc_d = pc_q + OPND_W'(1);
      case (op)
         OP_JMP:                            pc_d = arg;
         OP_JZ:                             if (z_q) pc_d = arg;
         OP_JC:                             if (c_q) pc_d = arg;
         OP_HLT, OP_RSVC, OP_RSVD, OP_RSVE: pc_d = pc_q;
         default:                           ;
      endcase
   end

   // Load port owns the memories whenever the core is not executing.
   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         if (prog_dmem) dmem[prog_addr] <= prog_wdata;
         else           imem[prog_addr] <= prog_wdata[IW-1:0];
      end else if (!rst && state_q == ST_EXEC && op == OP_STA) begin
         dmem[arg] <= acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         pc_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         halt_q  <= 1'b0;
         ill_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_q <= ST_FETCH;
            ST_FETCH: begin
               ir_q    <= imem[pc_q];
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               pc_q <= pc_d;
               if (ret_q != '1) ret_q <= ret_q + CNT_W'(1);
               case (op)
                  OP_LDA, OP_LDI, OP_AND, OP_OR, OP_XOR: begin
                     acc_q <= alu_res;
                     z_q   <= alu_z;
                  end
                  OP_ADD, OP_SUB: begin
                     acc_q <= alu_res;
                     z_q   <= alu_z;
                     c_q   <= alu_c;
                  end
                  default: ;
               endcase
               if (op == OP_HLT || is_reserved(op)) begin
                  state_q <= ST_HALT;
                  ill_q   <= ill_q | is_reserved(op);
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            ST_HALT: begin
               // halt is a registered view of the HALT state, so it trails entry by one edge.
               if (start) begin
                  pc_q    <= '0;
                  halt_q  <= 1'b0;
                  state_q <= ST_FETCH;
               end else begin
                  halt_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pc      = pc_q;
   assign acc     = acc_q;
   assign zero    = z_q;
   assign carry   = c_q;
   assign halt    = halt_q;
   assign illegal = ill_q;
   assign retired = ret_q;

endmodule
